// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: four-digit BCD up/down counter with a digit-scan mux feeding a seven-segment decoder.
// Optional build macro: BCD_LEADING_ZERO_BLANK_EN (blanks leading-zero digits 3..1 on the anodes).
`default_nettype none

module bcd_scan_counter #(
  parameter int TICK_DIV = 100000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  output logic [15:0] count,
  output logic        wrap,
  output logic [3:0]  bcd_out,
  output logic [3:0]  an
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    bcd_out_q, bcd_out_d;
  logic [3:0]    an_q, an_d;

  logic          step;
  logic [15:0]   stepped;
  logic          carry_out;

  assign step = en && (tcnt_q == TICK_LAST);

  // Ripple one digit at a time; the carry/borrow left over after digit 3 is the wrap.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    stepped = count_q;
    carry   = 1'b1;
    digit   = 4'h0;
    for (int k = 0; k < 4; k++) begin
      digit = count_q[4*k +: 4];
      if (carry) begin
        if (up) begin
          if (digit >= 4'd9) begin
            stepped[4*k +: 4] = 4'd0;
          end else begin
            stepped[4*k +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            stepped[4*k +: 4] = 4'd9;
          end else begin
            stepped[4*k +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    carry_out = carry;
  end

  always_comb begin
    tcnt_d  = tcnt_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      tcnt_d  = '0;
      count_d = 16'h0000;
    end else if (en) begin
      if (step) begin
        tcnt_d  = '0;
        count_d = stepped;
        wrap_d  = carry_out;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  always_comb begin
    scnt_d = scnt_q + SW'(1);
    idx_d  = idx_q;
    if (scnt_q == SCAN_LAST) begin
      scnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [3:0] lead_zero;
  always_comb begin
    lead_zero[3] = (count_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (count_q[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (count_q[7:4] == 4'd0);
    lead_zero[0] = 1'b0;
  end
`endif

  // Digit and anode come from the same idx_q, so they stay paired after the register.
  always_comb begin
    bcd_out_d = count_q[4*idx_q +: 4];
    an_d      = ~(4'b0001 << idx_q);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    if (lead_zero[idx_q]) begin
      an_d = 4'b1111;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q    <= '0;
      scnt_q    <= '0;
      idx_q     <= 2'd0;
      count_q   <= 16'h0000;
      wrap_q    <= 1'b0;
      bcd_out_q <= 4'h0;
      an_q      <= 4'b1110;
    end else begin
      tcnt_q    <= tcnt_d;
      scnt_q    <= scnt_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      bcd_out_q <= bcd_out_d;
      an_q      <= an_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign bcd_out = bcd_out_q;
  assign an      = an_q;

endmodule

`default_nettype wire
